// File: rtl/pkt_134b_rx_buffer_if.sv
// Beat bus for pkt_134b_rx_buffer: upstream beat input, downstream valid/ready beat output,
// upstream ready and the packet statistics counters.
//   slave  : the buffer side (consumes i_*, drives o_*).
//   master : the environment side (drives i_*, observes o_*).
interface pkt_134b_rx_buffer_if;
    logic         i_pkt_valid;
    logic [133:0] i_pkt_data;
    logic [15:0]  i_pkt_length;
    logic         o_ready_up;
    logic         o_pkt_valid;
    logic [133:0] o_pkt_data;
    logic [15:0]  o_pkt_length;
    logic         i_ready;
    logic [31:0]  o_cnt_pkt_in;
    logic [31:0]  o_cnt_pkt_drop;

    modport slave (
        input  i_pkt_valid, i_pkt_data, i_pkt_length, i_ready,
        output o_ready_up, o_pkt_valid, o_pkt_data, o_pkt_length, o_cnt_pkt_in, o_cnt_pkt_drop
    );

    modport master (
        output i_pkt_valid, i_pkt_data, i_pkt_length, i_ready,
        input  o_ready_up, o_pkt_valid, o_pkt_data, o_pkt_length, o_cnt_pkt_in, o_cnt_pkt_drop
    );
endinterface

// File: rtl/pkt_134b_rx_buffer.sv
// Packet-store FIFO for 134b beats. Writes packets speculatively, commits only whole packets,
// drops packets that do not fit (or are malformed) and replays committed packets through a
// registered valid/ready output stage.
// Ports:
//   clk    - single clock, rising edge
//   rst_n  - asynchronous active-low reset, clears everything including stored packets
//   pkt_if - beat bus (slave): i_pkt_valid/i_pkt_data/i_pkt_length in, o_ready_up,
//            o_pkt_valid/o_pkt_data/o_pkt_length out with i_ready, packet counters out
module pkt_134b_rx_buffer #(
    parameter int unsigned ADDR_W        = 8,
    parameter int unsigned LEN_ADDR_W    = 4,
    parameter int unsigned META_BEATS    = 1,
    parameter int unsigned MAX_PKT_BEATS = 97
) (
    input logic                  clk,
    input logic                  rst_n,
    pkt_134b_rx_buffer_if.slave  pkt_if
);
    localparam int unsigned Depth    = 2 ** ADDR_W;
    localparam int unsigned LenDepth = 2 ** LEN_ADDR_W;

    typedef logic [ADDR_W:0]     ptr_t;
    typedef logic [LEN_ADDR_W:0] lptr_t;
    typedef enum logic [1:0] {StIdle, StWrite, StDrop} state_e;

    state_e       state_q, state_d;
    ptr_t         wr_ptr_q, wr_ptr_d, cm_ptr_q, cm_ptr_d, rd_ptr_q, rd_ptr_d;
    ptr_t         cm_vis_q;  // commit pointer as seen by the reader, one cycle late
    lptr_t        lw_ptr_q, lw_ptr_d, lr_ptr_q, lr_ptr_d;
    logic [15:0]  len_q, len_d;  // length of the packet being written
    logic         stray_q, stray_d;
    logic [31:0]  cnt_in_q, cnt_in_d, cnt_drop_q;
    logic [1:0]   drop_inc;
    logic         ready_up_q;
    logic         out_valid_q, out_valid_d;
    logic [133:0] out_data_q, out_data_d;
    logic [15:0]  out_len_q, out_len_d;

    logic [133:0] mem [Depth];
    logic [15:0]  len_mem [LenDepth];

    logic              mem_we, len_we, start_head;
    logic [ADDR_W-1:0] mem_waddr;
    logic [15:0]       len_wdata;

    logic              is_head, is_tail, buf_full, lfull, head_fits;
    ptr_t              used_wr, used_cm;
    logic [16:0]       free_wr, free_cm, need;

    assign is_head = pkt_if.i_pkt_data[132];
    assign is_tail = pkt_if.i_pkt_data[133];

    assign used_wr  = wr_ptr_q - rd_ptr_q;
    assign used_cm  = cm_ptr_q - rd_ptr_q;
    assign free_wr  = 17'(Depth) - 17'(used_wr);
    assign free_cm  = 17'(Depth) - 17'(used_cm);
    assign buf_full = used_wr[ADDR_W];
    assign lfull    = (lw_ptr_q ^ lr_ptr_q) == {1'b1, {LEN_ADDR_W{1'b0}}};
    assign need     = ((({1'b0, pkt_if.i_pkt_length}) + 17'd15) >> 4) + 17'(META_BEATS);
    // A new head always restarts from the commit pointer, so a rollback in WRITE and the
    // admission check of the new head can happen in the same cycle.
    assign head_fits = (need <= free_cm) && !lfull;

    // Write side
    always_comb begin
        state_d    = state_q;
        wr_ptr_d   = wr_ptr_q;
        cm_ptr_d   = cm_ptr_q;
        len_d      = len_q;
        stray_d    = 1'b0;
        cnt_in_d   = cnt_in_q;
        drop_inc   = 2'd0;
        mem_we     = 1'b0;
        mem_waddr  = wr_ptr_q[ADDR_W-1:0];
        len_we     = 1'b0;
        len_wdata  = len_q;
        start_head = 1'b0;

        if (pkt_if.i_pkt_valid) begin
            case (state_q)
                StIdle, StDrop: begin
                    if (is_head) begin
                        start_head = 1'b1;
                    end else if (state_q == StIdle) begin
                        // A run of stray beats counts as a single drop.
                        stray_d = 1'b1;
                        if (!stray_q) drop_inc = 2'd1;
                    end else if (is_tail) begin
                        state_d = StIdle;
                    end
                end
                StWrite: begin
                    if (is_head) begin
                        wr_ptr_d   = cm_ptr_q;
                        drop_inc   = 2'd1;
                        start_head = 1'b1;
                    end else if (buf_full) begin
                        wr_ptr_d = cm_ptr_q;
                        drop_inc = 2'd1;
                        state_d  = StDrop;
                    end else begin
                        mem_we   = 1'b1;
                        wr_ptr_d = wr_ptr_q + ptr_t'(1);
                        if (is_tail) begin
                            cm_ptr_d = wr_ptr_q + ptr_t'(1);
                            len_we   = 1'b1;
                            cnt_in_d = cnt_in_q + 32'd1;
                            state_d  = StIdle;
                        end
                    end
                end
                default: state_d = StIdle;
            endcase

            if (start_head) begin
                if (head_fits) begin
                    mem_we    = 1'b1;
                    mem_waddr = cm_ptr_q[ADDR_W-1:0];
                    wr_ptr_d  = cm_ptr_q + ptr_t'(1);
                    len_d     = pkt_if.i_pkt_length;
                    if (is_tail) begin
                        cm_ptr_d  = cm_ptr_q + ptr_t'(1);
                        len_we    = 1'b1;
                        len_wdata = pkt_if.i_pkt_length;
                        cnt_in_d  = cnt_in_q + 32'd1;
                        state_d   = StIdle;
                    end else begin
                        state_d = StWrite;
                    end
                end else begin
                    drop_inc = drop_inc + 2'd1;
                    state_d  = StDrop;
                end
            end
        end
        lw_ptr_d = lw_ptr_q + lptr_t'(len_we);
    end

    // Read side
    logic                  lpop, load;
    logic [133:0]          rd_beat;
    logic [LEN_ADDR_W-1:0] lr_idx;

    assign rd_beat = mem[rd_ptr_q[ADDR_W-1:0]];
    assign lpop    = out_valid_q & pkt_if.i_ready & out_data_q[133];
    assign load    = (!out_valid_q | pkt_if.i_ready) & (rd_ptr_q != cm_vis_q);
    // A head loaded in the same cycle its predecessor's tail is accepted needs the next entry.
    assign lr_idx  = lr_ptr_q[LEN_ADDR_W-1:0] + {{(LEN_ADDR_W-1){1'b0}}, lpop};

    always_comb begin
        out_valid_d = out_valid_q;
        out_data_d  = out_data_q;
        out_len_d   = out_len_q;
        rd_ptr_d    = rd_ptr_q + ptr_t'(load);
        lr_ptr_d    = lr_ptr_q + lptr_t'(lpop);
        if (load) begin
            out_valid_d = 1'b1;
            out_data_d  = rd_beat;
            if (rd_beat[132]) out_len_d = len_mem[lr_idx];
        end else if (out_valid_q && pkt_if.i_ready) begin
            out_valid_d = 1'b0;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= StIdle;
            wr_ptr_q    <= '0;
            cm_ptr_q    <= '0;
            cm_vis_q    <= '0;
            rd_ptr_q    <= '0;
            lw_ptr_q    <= '0;
            lr_ptr_q    <= '0;
            len_q       <= '0;
            stray_q     <= 1'b0;
            cnt_in_q    <= '0;
            cnt_drop_q  <= '0;
            ready_up_q  <= 1'b1;
            out_valid_q <= 1'b0;
            out_data_q  <= '0;
            out_len_q   <= '0;
        end else begin
            state_q     <= state_d;
            wr_ptr_q    <= wr_ptr_d;
            cm_ptr_q    <= cm_ptr_d;
            cm_vis_q    <= cm_ptr_q;
            rd_ptr_q    <= rd_ptr_d;
            lw_ptr_q    <= lw_ptr_d;
            lr_ptr_q    <= lr_ptr_d;
            len_q       <= len_d;
            stray_q     <= stray_d;
            cnt_in_q    <= cnt_in_d;
            cnt_drop_q  <= cnt_drop_q + 32'(drop_inc);
            ready_up_q  <= (free_wr >= 17'(MAX_PKT_BEATS)) & !lfull;
            out_valid_q <= out_valid_d;
            out_data_q  <= out_data_d;
            out_len_q   <= out_len_d;
        end
    end

    // Storage arrays carry no reset; pointers define what is valid.
    always_ff @(posedge clk) begin
        if (mem_we) mem[mem_waddr] <= pkt_if.i_pkt_data;
        if (len_we) len_mem[lw_ptr_q[LEN_ADDR_W-1:0]] <= len_wdata;
    end

    assign pkt_if.o_ready_up     = ready_up_q;
    assign pkt_if.o_pkt_valid    = out_valid_q;
    assign pkt_if.o_pkt_data     = out_data_q;
    assign pkt_if.o_pkt_length   = out_len_q;
    assign pkt_if.o_cnt_pkt_in   = cnt_in_q;
    assign pkt_if.o_cnt_pkt_drop = cnt_drop_q;
endmodule
